serial_paralelo: RTL and testbench

Serial-to-parallel receiver for the PCIE18 physical-layer lane. It takes the one-bit stream produced by the lane's parallel-to-serial transmitter and aligns to byte boundaries by searching for consecutive COM symbols. After alignment it reassembles `cantBits`-wide symbols and presents each one with a one-cycle valid strobe. It sits at the receive end of the lane and feeds the deskew/logic layer.

---
 rtl/serial_paralelo_if.sv | 27 ++
 rtl/serial_paralelo.sv | 94 +++++++++
 tb/tb_serial_paralelo.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/serial_paralelo_if.sv
// Lane-side bundle for the serial-to-parallel receiver: serial bit input plus
// the reassembled symbol, its strobe and the alignment status.
interface serial_paralelo_if #(
    parameter int cantBits = 8
);
    logic                enb;
    logic                entrada;
    logic [cantBits-1:0] salida;
    logic                valid;
    logic                active;

    modport master (
        output enb,
        output entrada,
        input  salida,
        input  valid,
        input  active
    );

    modport slave (
        input  enb,
        input  entrada,
        output salida,
        output valid,
        output active
    );
endinterface

// File: rtl/serial_paralelo.sv
// Serial-to-parallel lane receiver: locks onto symbol boundaries after numCOM
// consecutive aligned COM symbols, then emits each symbol with a valid strobe.
module serial_paralelo #(
    parameter int                  cantBits = 8,
    parameter logic [cantBits-1:0] COM      = 8'hBC,
    parameter int                  numCOM   = 4
) (
    input  logic             clk,
    input  logic             reset,
    serial_paralelo_if.slave lane
);
    localparam int BCW = (cantBits > 1) ? $clog2(cantBits) : 1;
    localparam int CCW = $clog2(numCOM + 1);
    localparam logic [BCW-1:0] LAST = BCW'(cantBits - 1);
    localparam logic [CCW-1:0] NCOM = CCW'(numCOM);

    typedef enum logic {ST_INACTIVE, ST_ACTIVE} state_t;

    state_t              state_q, state_d;
    logic [cantBits-1:0] sr_q, sr_d;
    logic [cantBits-1:0] salida_q, salida_d;
    logic [BCW-1:0]      bitCnt_q, bitCnt_d;
    logic [CCW-1:0]      comCnt_q, comCnt_d;
    logic                valid_q, valid_d;
    logic [cantBits-1:0] window;
    logic                at_boundary;
    logic                com_hit;

    // window is the shift register contents once the current bit is shifted in
    assign window      = {sr_q[cantBits-2:0], lane.entrada};
    assign at_boundary = (bitCnt_q == LAST);
    assign com_hit     = (window == COM);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_INACTIVE;
            sr_q     <= '0;
            salida_q <= '0;
            bitCnt_q <= '0;
            comCnt_q <= '0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            sr_q     <= sr_d;
            salida_q <= salida_d;
            bitCnt_q <= bitCnt_d;
            comCnt_q <= comCnt_d;
            valid_q  <= valid_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        sr_d     = sr_q;
        salida_d = salida_q;
        bitCnt_d = bitCnt_q;
        comCnt_d = comCnt_q;
        valid_d  = 1'b0;
        if (lane.enb) begin
            sr_d = window;
            if (state_q == ST_INACTIVE) begin
                // A COM with no count pending may sit anywhere and realigns the boundary
                if (com_hit && (comCnt_q == '0 || at_boundary)) begin
                    bitCnt_d = '0;
                    if (comCnt_q != NCOM) begin
                        comCnt_d = comCnt_q + 1'b1;
                    end
                    if (comCnt_d == NCOM) begin
                        state_d = ST_ACTIVE;
                    end
                end else if (at_boundary) begin
                    comCnt_d = '0;
                    bitCnt_d = '0;
                end else begin
                    bitCnt_d = bitCnt_q + 1'b1;
                end
            end else begin
                if (at_boundary) begin
                    salida_d = window;
                    valid_d  = 1'b1;
                    bitCnt_d = '0;
                end else begin
                    bitCnt_d = bitCnt_q + 1'b1;
                end
            end
        end
    end

    always_comb begin
        lane.active = (state_q == ST_ACTIVE);
        lane.salida = salida_q;
        lane.valid  = valid_q;
    end
endmodule

// File: tb/tb_serial_paralelo.sv
// Bench for serial_paralelo: directed scenarios plus randomized traffic, all
// compared cycle by cycle against a bit-history reference model.
module tb_serial_paralelo;
    localparam int           W    = 8;
    localparam logic [W-1:0] COM  = 8'hBC;
    localparam int           NCOM = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    serial_paralelo_if #(.cantBits(W)) lane ();

    serial_paralelo #(.cantBits(W), .COM(COM), .numCOM(NCOM)) dut (
        .clk   (clk),
        .reset (reset),
        .lane  (lane)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference model: the received bit history, the index where the current
    // symbol began, the count of accepted COMs and the expected outputs.
    bit           rx_q[$];
    int           bnd      = 0;
    int           ncom     = 0;
    bit           m_active = 1'b0;
    bit           m_valid  = 1'b0;
    logic [W-1:0] m_salida = '0;
    logic [W-1:0] got_q[$];

    function automatic logic [W-1:0] last_bits();
        logic [W-1:0] w;
        w = '0;
        for (int i = 0; i < W; i++) begin
            int idx;
            idx = rx_q.size() - W + i;
            w = {w[W-2:0], (idx >= 0) ? rx_q[idx] : 1'b0};
        end
        return w;
    endfunction

    task automatic model_edge(input logic r, input logic e, input logic d);
        logic [W-1:0] w;
        int n;
        if (r) begin
            rx_q.delete();
            bnd      = 0;
            ncom     = 0;
            m_active = 1'b0;
            m_valid  = 1'b0;
            m_salida = '0;
        end else begin
            m_valid = 1'b0;
            if (e) begin
                rx_q.push_back(d);
                w = last_bits();
                n = rx_q.size() - bnd;
                if (!m_active) begin
                    if (w == COM && (ncom == 0 || n == W)) begin
                        ncom++;
                        bnd = rx_q.size();
                        if (ncom == NCOM) m_active = 1'b1;
                    end else if (n == W) begin
                        ncom = 0;
                        bnd  = rx_q.size();
                    end
                end else if (n == W) begin
                    m_salida = w;
                    m_valid  = 1'b1;
                    bnd      = rx_q.size();
                end
            end
        end
    endtask

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic r, input logic e, input logic d);
        reset        = r;
        lane.enb     = e;
        lane.entrada = d;
        @(posedge clk);
        model_edge(r, e, d);
        #1;
        check("salida", lane.salida, m_salida);
        check("valid", W'(lane.valid), W'(m_valid));
        check("active", W'(lane.active), W'(m_active));
        if (lane.valid === 1'b1) got_q.push_back(lane.salida);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0);
        got_q.delete();
    endtask

    // gap_at: number of bits sent before an idle stretch of gap_len enb=0 cycles
    task automatic send_byte(input logic [W-1:0] b, input int gap_at, input int gap_len);
        for (int i = 0; i < W; i++) begin
            if (i == gap_at) begin
                for (int g = 0; g < gap_len; g++) step(1'b0, 1'b0, 1'($urandom_range(1)));
            end
            step(1'b0, 1'b1, b[W-1-i]);
        end
    endtask

    task automatic send_coms(input int n);
        for (int i = 0; i < n; i++) send_byte(COM, -1, 0);
    endtask

    initial begin
        lane.enb     = 1'b0;
        lane.entrada = 1'b0;

        // Reset then a long run of zeros: nothing may come out
        do_reset(3);
        for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b0);
        check("zeros_nsym", W'(got_q.size()), W'(0));

        // Alignment after a short preamble
        do_reset(1);
        step(1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        send_coms(3);
        check("align_pre", W'(lane.active), W'(0));
        send_coms(1);
        check("align_on", W'(lane.active), W'(1));
        send_byte(8'h5A, -1, 0);
        step(1'b0, 1'b1, 1'b0);
        check("align_nsym", W'(got_q.size()), W'(1));
        if (got_q.size() > 0) check("align_sym", got_q[0], 8'h5A);

        // Broken COM sequence restarts the count
        do_reset(2);
        send_coms(2);
        send_byte(8'h00, -1, 0);
        send_coms(3);
        check("broken_pre", W'(lane.active), W'(0));
        send_coms(1);
        check("broken_on", W'(lane.active), W'(1));
        send_byte(8'hA5, -1, 0);
        check("broken_nsym", W'(got_q.size()), W'(1));
        if (got_q.size() > 0) check("broken_sym", got_q[0], 8'hA5);

        // COM shifted off the boundary
        do_reset(1);
        send_coms(2);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
        send_byte(COM, -1, 0);
        check("shift_pre", W'(lane.active), W'(0));
        send_coms(4);
        check("shift_on", W'(lane.active), W'(1));

        // Idle enb cycles in the middle of a symbol
        got_q.delete();
        send_byte(8'h12, 3, 5);
        send_byte(8'h34, -1, 0);
        check("gate_nsym", W'(got_q.size()), W'(2));
        if (got_q.size() > 1) begin
            check("gate_sym0", got_q[0], 8'h12);
            check("gate_sym1", got_q[1], 8'h34);
        end

        // Reset in the middle of a symbol discards everything
        for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'b1);
        do_reset(1);
        check("mid_active", W'(lane.active), W'(0));
        check("mid_salida", lane.salida, 8'h00);
        send_coms(3);
        check("mid_pre", W'(lane.active), W'(0));
        send_coms(1);
        check("mid_on", W'(lane.active), W'(1));
        send_byte(8'h3C, -1, 0);
        check("mid_nsym", W'(got_q.size()), W'(1));
        if (got_q.size() > 0) check("mid_sym", got_q[0], 8'h3C);

        // Randomized traffic: noise, alignment, gapped data and a reset mid-run
        do_reset(1);
        for (int i = 0; i < 60; i++) step(1'b0, 1'($urandom_range(3) != 0), 1'($urandom_range(1)));
        for (int pass = 0; pass < 2; pass++) begin
            send_coms(NCOM + 1);
            for (int k = 0; k < 30; k++) begin
                if ($urandom_range(3) == 0)
                    send_byte(W'($urandom), int'($urandom_range(W - 1)), int'($urandom_range(4, 1)));
                else
                    send_byte(W'($urandom), -1, 0);
            end
            for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'($urandom_range(1)));
            do_reset(1 + pass);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
